data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
MEM-stage memory controller between the pipeline datapath's data-memory port and a req/ack data bus. It converts the datapath's single-cycle mem_ren/mem_wen/mem_addr/mem_dout/mem_din contract into a multi-cycle bus handshake. While an access is outstanding it drives mem_stall so the pipeline freezes, and it returns the load data in the cycle the stall releases. It also detects misaligned accesses, conflicting read/write requests, and bus timeouts.

Parameters:
TIMEOUT, 16, number of WAIT cycles without bus_ack before the access aborts (must be >= 1).
ADDR_W, 32, width of bus_addr.

Ports:
clk  in  1  main clock, rising edge.
cpu_rst  in  1  reset, synchronous, active-high.
cpu_en  in  1  CPU enable; the pipeline advances only when it is high.
mem_ren  in  1  load request from the MEM stage.
mem_wen  in  1  store request from the MEM stage.
mem_addr  in  32  byte address from the MEM stage.
mem_dout  in  32  store data from the MEM stage.
mem_din  out  32  load data to the MEM stage.
mem_stall  out  1  pipeline freeze; the datapath ANDs ~mem_stall into its stage enables.
mem_err  out  1  sticky error flag: misaligned access, ren&wen conflict, or timeout.
bus_req  out  1  bus request, registered.
bus_we  out  1  1 = write, 0 = read; registered; valid while bus_req is high.
bus_addr  out  ADDR_W  word-aligned bus address, registered.
bus_wdata  out  32  bus write data, registered.
bus_rdata  in  32  bus read data; sampled on the bus_ack cycle.
bus_ack  in  1  single-cycle completion strobe from the bus.

Behaviour:
- Reset (cpu_rst=1 at a clock edge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_q=0, mem_err=0, timeout counter=0.
- While cpu_rst=1, mem_stall=0 combinationally.
- Definitions:
  - go = cpu_en & (mem_ren ^ mem_wen) & (mem_addr[1:0]==0)
  - bad = cpu_en & ((mem_ren & mem_wen) | ((mem_ren|mem_wen) & mem_addr[1:0]!=0))
- IDLE:
  - mem_stall = go (combinational); mem_din = 0.
  - On go: latch bus_addr=mem_addr[ADDR_W-1:0], bus_wdata=mem_dout, bus_we=mem_wen; set bus_req=1; clear the counter; next state WAIT.
  - On bad: set mem_err=1, start no bus access, no stall, stay IDLE.
  - bus_ack is ignored in IDLE.
- WAIT:
  - mem_stall=1. bus_req, bus_we, bus_addr and bus_wdata are held stable.
  - bus_ack=1: rdata_q = bus_we ? 0 : bus_rdata; bus_req=0; next state DONE.
  - Else if counter == TIMEOUT-1: bus_req=0, rdata_q=0, mem_err=1; next state DONE.
  - Else: counter+1.
  - WAIT is independent of cpu_en; an in-flight bus transaction always completes or times out.
- DONE:
  - mem_stall=0; mem_din=rdata_q.
  - cpu_en=1: next state IDLE. The pipeline advances at this edge, and the same request is not reissued.
  - cpu_en=0: stay in DONE and keep mem_din stable.
- Latency: with bus_ack in the first WAIT cycle, a load stalls for exactly 2 cycles (IDLE+go, WAIT) and data appears in DONE. Each extra bus wait cycle adds 1 stall cycle. A timeout stalls for TIMEOUT+1 cycles.
- Back-to-back memory instructions: after DONE, the next instruction's request is evaluated in IDLE. The minimum spacing is therefore 3 cycles per access.
- mem_err stays 1 until cpu_rst. Once set, it does not block later accesses.
- Reset during WAIT: bus_req=0 at that edge. A late bus_ack after reset is ignored.
- Out of scope: byte and halfword accesses. Any access with addr[1:0]!=0 is an error.

Test Plan:
1. Load, addr 0x0000_0010, bus_ack on the 1st WAIT cycle with bus_rdata=0xDEAD_BEEF -> mem_stall high for 2 cycles; in DONE, mem_din=0xDEADBEEF, bus_req=0, mem_err=0.
2. Store, addr 0x0000_0020, mem_dout=0x1234_5678, bus_ack after 3 WAIT cycles -> bus_we=1, bus_addr=0x20, bus_wdata=0x12345678, all stable for 3 cycles; mem_stall high for 4 cycles; mem_din=0 in DONE.
3. Load, addr 0x0000_0004, no bus_ack, TIMEOUT=16 -> bus_req drops after 16 WAIT cycles; mem_err=1; mem_din=0; the pipeline resumes; a subsequent good load still completes normally.
4. Misaligned load (addr 0x0000_0006), then mem_ren=mem_wen=1 -> no bus_req, mem_stall=0 in both cases, mem_err=1 and stays 1.
5. cpu_rst asserted in the 2nd WAIT cycle, then bus_ack pulsed the next cycle -> bus_req=0, state IDLE, mem_err=0, mem_stall=0, and the ack is ignored (mem_din=0).
6. Load completes with cpu_en=0 held for 3 cycles in DONE, then a store follows -> mem_din is held for all 3 cycles with no second bus_req; the store starts in the IDLE cycle after cpu_en returns.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: turns single-cycle load/store requests
// into a req/ack bus handshake, stalling the pipeline while an access is in flight.
module data_mem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              cpu_rst,
    input  logic              cpu_en,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       mem_din,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                aligned_s;
    logic                go_s;
    logic                bad_s;

    assign aligned_s = (mem_addr[1:0] == 2'b00);
    assign go_s      = cpu_en & (mem_ren ^ mem_wen) & aligned_s;
    assign bad_s     = cpu_en & ((mem_ren & mem_wen) | ((mem_ren | mem_wen) & ~aligned_s));

    // Next-state, bus register and pipeline-facing output logic
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mem_stall   = 1'b0;
        mem_din     = 32'd0;
        case (state_q)
            ST_IDLE: begin
                mem_stall = go_s;
                if (go_s) begin
                    bus_addr_d  = mem_addr[ADDR_W-1:0];
                    bus_wdata_d = mem_dout;
                    bus_we_d    = mem_wen;
                    bus_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WAIT;
                end else if (bad_s) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // In-flight transactions finish regardless of cpu_en
                mem_stall = 1'b1;
                if (bus_ack) begin
                    rdata_d   = bus_we_q ? 32'd0 : bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = 32'd0;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                mem_din = rdata_q;
                if (cpu_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
        if (cpu_rst) begin
            mem_stall = 1'b0;
        end else begin
            mem_stall = mem_stall;
        end
    end

    // State and bus registers with synchronous reset
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_err   = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (TIMEOUT=16, ADDR_W=32).
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        cpu_rst, cpu_en, mem_ren, mem_wen, bus_ack;
    logic [31:0] mem_addr, mem_dout, mem_din, bus_addr, bus_wdata, bus_rdata;
    logic        mem_stall, mem_err, bus_req, bus_we;
    int          n_total = 0;
    int          n_pass  = 0;

    data_mem_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk(clk), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .mem_stall(mem_stall),
        .mem_err(mem_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cpu_rst = 1'b1; step(); cpu_rst = 1'b0; #1;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1; cpu_en = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h10;
        mem_dout = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        step(); step(); #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", mem_stall); else n_pass++;
        n_total++; if (bus_req !== 1'b0 || bus_we !== 1'b0) $display("FAIL rst_bus: req=%0b we=%0b want 0 0", bus_req, bus_we); else n_pass++;
        n_total++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) $display("FAIL rst_bus_data: addr=%h wdata=%h want 0 0", bus_addr, bus_wdata); else n_pass++;
        n_total++; if (mem_din !== 32'h0 || mem_err !== 1'b0) $display("FAIL rst_din_err: din=%h err=%0b want 0 0", mem_din, mem_err); else n_pass++;
        mem_ren = 1'b0; cpu_rst = 1'b0; step();
    endtask

    task automatic test_load_fast();
        mem_ren = 1'b1; mem_addr = 32'h10; #1;
        n_total++; if (mem_stall !== 1'b1) $display("FAIL t1_stall_idle: got %0b want 1", mem_stall); else n_pass++;
        step();
        n_total++; if (mem_stall !== 1'b1 || bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h10)
            $display("FAIL t1_wait: stall=%0b req=%0b we=%0b addr=%h want 1 1 0 00000010", mem_stall, bus_req, bus_we, bus_addr); else n_pass++;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; step(); bus_ack = 1'b0; bus_rdata = 32'h0; #1;
        n_total++; if (mem_stall !== 1'b0 || mem_din !== 32'hDEAD_BEEF || bus_req !== 1'b0 || mem_err !== 1'b0)
            $display("FAIL t1_done: stall=%0b din=%h req=%0b err=%0b want 0 deadbeef 0 0", mem_stall, mem_din, bus_req, mem_err); else n_pass++;
        step(); mem_ren = 1'b0; #1;
        n_total++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) $display("FAIL t1_no_reissue: stall=%0b req=%0b want 0 0", mem_stall, bus_req); else n_pass++;
    endtask

    task automatic test_store_slow();
        int bad = 0;
        mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'h1234_5678; #1;
        n_total++; if (mem_stall !== 1'b1) $display("FAIL t2_stall_idle: got %0b want 1", mem_stall); else n_pass++;
        step();
        for (int i = 0; i < 3; i++) begin
            if (mem_stall !== 1'b1 || bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h20 || bus_wdata !== 32'h1234_5678) bad++;
            bus_ack = (i == 2) ? 1'b1 : 1'b0;
            bus_rdata = 32'hFFFF_FFFF;
            step();
        end
        bus_ack = 1'b0; #1;
        n_total++; if (bad != 0) $display("FAIL t2_wait_stable: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (mem_stall !== 1'b0 || mem_din !== 32'h0 || bus_req !== 1'b0)
            $display("FAIL t2_done: stall=%0b din=%h req=%0b want 0 0 0", mem_stall, mem_din, bus_req); else n_pass++;
        step(); mem_wen = 1'b0;
    endtask

    task automatic test_timeout();
        int bad = 0;
        mem_ren = 1'b1; mem_addr = 32'h4; step();
        for (int i = 0; i < 16; i++) begin
            if (mem_stall !== 1'b1 || bus_req !== 1'b1) bad++;
            step();
        end
        n_total++; if (bad != 0) $display("FAIL t3_wait: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (bus_req !== 1'b0 || mem_err !== 1'b1 || mem_din !== 32'h0 || mem_stall !== 1'b0)
            $display("FAIL t3_abort: req=%0b err=%0b din=%h stall=%0b want 0 1 0 0", bus_req, mem_err, mem_din, mem_stall); else n_pass++;
        step();
        mem_addr = 32'h8; step();
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; step(); bus_ack = 1'b0; #1;
        n_total++; if (mem_din !== 32'hCAFE_F00D || mem_err !== 1'b1)
            $display("FAIL t3_after: din=%h err=%0b want cafef00d 1", mem_din, mem_err); else n_pass++;
        step(); mem_ren = 1'b0;
    endtask

    task automatic test_errors();
        apply_reset();
        mem_ren = 1'b1; mem_addr = 32'h6; #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL t4_mis_stall: got %0b want 0", mem_stall); else n_pass++;
        step();
        n_total++; if (bus_req !== 1'b0 || mem_err !== 1'b1) $display("FAIL t4_mis: req=%0b err=%0b want 0 1", bus_req, mem_err); else n_pass++;
        mem_wen = 1'b1; mem_addr = 32'h10; #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL t4_conf_stall: got %0b want 0", mem_stall); else n_pass++;
        step();
        n_total++; if (bus_req !== 1'b0 || mem_err !== 1'b1) $display("FAIL t4_conf: req=%0b err=%0b want 0 1", bus_req, mem_err); else n_pass++;
        mem_ren = 1'b0; mem_wen = 1'b0; step(); step();
        n_total++; if (mem_err !== 1'b1) $display("FAIL t4_sticky: got %0b want 1", mem_err); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        mem_ren = 1'b1; mem_addr = 32'h30; step(); step();
        cpu_rst = 1'b1; #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL t5_stall_in_rst: got %0b want 0", mem_stall); else n_pass++;
        step(); cpu_rst = 1'b0; mem_ren = 1'b0; #1;
        n_total++; if (bus_req !== 1'b0 || mem_err !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL t5_after_rst: req=%0b err=%0b stall=%0b want 0 0 0", bus_req, mem_err, mem_stall); else n_pass++;
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555; step(); bus_ack = 1'b0; #1;
        n_total++; if (mem_din !== 32'h0 || bus_req !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL t5_late_ack: din=%h req=%0b stall=%0b want 0 0 0", mem_din, bus_req, mem_stall); else n_pass++;
        step();
        n_total++; if (mem_din !== 32'h0) $display("FAIL t5_idle: din=%h want 0", mem_din); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        mem_ren = 1'b1; mem_addr = 32'h40; step();
        bus_ack = 1'b1; bus_rdata = 32'hA5A5_5A5A; step(); bus_ack = 1'b0; bus_rdata = 32'h0;
        cpu_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_din !== 32'hA5A5_5A5A || bus_req !== 1'b0 || mem_stall !== 1'b0) bad++;
            step();
        end
        n_total++; if (bad != 0) $display("FAIL t6_hold: got %0d bad cycles want 0", bad); else n_pass++;
        cpu_en = 1'b1; #1;
        n_total++; if (mem_din !== 32'hA5A5_5A5A || bus_req !== 1'b0)
            $display("FAIL t6_resume: din=%h req=%0b want a5a55a5a 0", mem_din, bus_req); else n_pass++;
        step();
        mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h44; mem_dout = 32'h0000_0099; #1;
        n_total++; if (mem_stall !== 1'b1 || bus_req !== 1'b0) $display("FAIL t6_store_idle: stall=%0b req=%0b want 1 0", mem_stall, bus_req); else n_pass++;
        step();
        n_total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h44 || bus_wdata !== 32'h99)
            $display("FAIL t6_store_wait: req=%0b we=%0b addr=%h wdata=%h want 1 1 44 99", bus_req, bus_we, bus_addr, bus_wdata); else n_pass++;
        bus_ack = 1'b1; step(); bus_ack = 1'b0; #1;
        n_total++; if (mem_din !== 32'h0 || mem_stall !== 1'b0) $display("FAIL t6_store_done: din=%h stall=%0b want 0 0", mem_din, mem_stall); else n_pass++;
        step(); mem_wen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_fast();
        test_store_slow();
        test_timeout();
        test_errors();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
